i2c_slave: RTL and testbench

I2C target (slave) that answers the team's `i2c_master` on the same two-wire bus, using the same byte framing: MSB-first, up to four bytes per transfer, and byte 0 mapped to bits 31:24. It runs in the system clock domain and oversamples SCL/SDA. It captures write transfers into a 32-bit word and serves read transfers from a 32-bit word supplied by the local side. It sits behind the bus pins, alongside the master, as the device-side endpoint for the APB–I2C bridge.

---
 rtl/i2c_pkg.sv | 52 +++++
 rtl/i2c_sync_edge.sv | 46 ++++
 rtl/i2c_slave.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared definitions for the I2C target and master.
//                - FSM state encoding for i2c_slave
//                - bit/byte counter widths
//                - maximum bytes per transfer (also bounds the master's
//                  byte count)
//                - helper that picks a byte from a 32-bit word,
//                  with byte 0 taken from bits 31:24
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_RX       = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_TX       = 3'd5,
        ST_TX_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } i2c_state_t;

    // Bit counter spans 0..8, byte counter spans 0..4.
    localparam int I2C_BIT_CNT_W  = 4;
    localparam int I2C_BYTE_CNT_W = 3;

    localparam logic [I2C_BYTE_CNT_W-1:0] I2C_MAX_BYTES = I2C_BYTE_CNT_W'(4);

    // Byte 'idx' of a transfer word, MSB byte first. Indices past the
    // last byte read as all-ones, which is what an idle bus looks like.
    function automatic logic [7:0] i2c_word_byte(
        input logic [31:0]               word,
        input logic [I2C_BYTE_CNT_W-1:0] idx
    );
        logic [7:0] b;
        b = 8'hFF;
        case (idx)
            3'd0:    b = word[31:24];
            3'd1:    b = word[23:16];
            3'd2:    b = word[15:8];
            3'd3:    b = word[7:0];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_sync_edge
//  Description : Two-flop synchronizer for an asynchronous bus pin followed
//                by a one-flop edge detector.
//  Ports       : clk   - system clock
//                rst   - asynchronous active-high reset
//                din   - raw pin value
//                lvl   - synchronized level
//                rise  - one-cycle pulse on a synchronized 0->1 transition
//                fall  - one-cycle pulse on a synchronized 1->0 transition
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to 1 so an idle (pulled-up) bus produces no edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign lvl  = r_sync;
    assign rise = r_sync & ~r_prev;
    assign fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_slave
//  Description : I2C target answering at a fixed 7-bit address. Oversamples
//                SCL/SDA in the system clock domain. Write transfers of up
//                to four bytes are collected into a 32-bit word (byte 0 in
//                bits 31:24, missing low bytes zero-filled); read transfers
//                are served MSB-first from a word latched at address match.
//                Never stretches SCL; SDA is only ever pulled low or released.
//  Ports       : clk       - system clock (>= 8x SCL)
//                rst       - asynchronous active-high reset
//                i2c_scl   - bus clock input
//                i2c_sda   - open-drain bus data
//                tx_data   - read-back word, latched on a read address match
//                rx_data   - last completed write word
//                rx_bytes  - byte count (0..4) of rx_data
//                rx_valid  - one-cycle pulse when a write transfer ends
//                busy      - high from address match until STOP
//                state_o   - current FSM state (debug)
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    input  logic [31:0] tx_data,
    output logic [31:0] rx_data,
    output logic [2:0]  rx_bytes,
    output logic        rx_valid,
    output logic        busy,
    output logic [2:0]  state_o
);

    // ------------------------------------------------------------------
    // Pin conditioning
    // ------------------------------------------------------------------
    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (i2c_scl),
        .lvl  (w_scl_lvl),
        .rise (w_scl_rise),
        .fall (w_scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (i2c_sda),
        .lvl  (w_sda),
        .rise (w_sda_rise),
        .fall (w_sda_fall)
    );

    // SCL level one sample earlier, recovered from level and edges. Judging
    // SDA edges against this keeps an SDA change that lands in the same
    // sample as an SCL rise from looking like START/STOP.
    logic w_scl_prev;
    logic w_start;
    logic w_stop;

    assign w_scl_prev = w_scl_fall | (w_scl_lvl & ~w_scl_rise);
    assign w_start    = w_sda_fall & w_scl_prev;
    assign w_stop     = w_sda_rise & w_scl_prev;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    i2c_state_t                r_state,     nxt_state;
    logic [I2C_BIT_CNT_W-1:0]  r_bit_cnt,   nxt_bit_cnt;
    logic [I2C_BYTE_CNT_W-1:0] r_byte_cnt,  nxt_byte_cnt;
    logic [7:0]                r_shift,     nxt_shift;
    logic [31:0]               r_tx_buf,    nxt_tx_buf;
    logic [31:0]               r_rx_buf,    nxt_rx_buf;
    logic                      r_is_write,  nxt_is_write;
    logic [31:0]               r_rx_data,   nxt_rx_data;
    logic [2:0]                r_rx_bytes,  nxt_rx_bytes;
    logic                      r_rx_valid,  nxt_rx_valid;
    logic                      r_busy,      nxt_busy;
    logic                      r_sda_oe,    nxt_sda_oe;

    logic [7:0]                w_shift_in;
    logic [7:0]                w_tx_byte;
    logic [I2C_BYTE_CNT_W-1:0] w_byte_inc;

    assign w_shift_in = {r_shift[6:0], w_sda};
    assign w_tx_byte  = i2c_word_byte(r_tx_buf, r_byte_cnt);
    assign w_byte_inc = (r_byte_cnt < I2C_MAX_BYTES) ? r_byte_cnt + 3'd1 : r_byte_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_tx_buf   <= '0;
            r_rx_buf   <= '0;
            r_is_write <= 1'b0;
            r_rx_data  <= '0;
            r_rx_bytes <= '0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_sda_oe   <= 1'b0;
        end else begin
            r_state    <= nxt_state;
            r_bit_cnt  <= nxt_bit_cnt;
            r_byte_cnt <= nxt_byte_cnt;
            r_shift    <= nxt_shift;
            r_tx_buf   <= nxt_tx_buf;
            r_rx_buf   <= nxt_rx_buf;
            r_is_write <= nxt_is_write;
            r_rx_data  <= nxt_rx_data;
            r_rx_bytes <= nxt_rx_bytes;
            r_rx_valid <= nxt_rx_valid;
            r_busy     <= nxt_busy;
            r_sda_oe   <= nxt_sda_oe;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state    = r_state;
        nxt_bit_cnt  = r_bit_cnt;
        nxt_byte_cnt = r_byte_cnt;
        nxt_shift    = r_shift;
        nxt_tx_buf   = r_tx_buf;
        nxt_rx_buf   = r_rx_buf;
        nxt_is_write = r_is_write;
        nxt_rx_data  = r_rx_data;
        nxt_rx_bytes = r_rx_bytes;
        nxt_rx_valid = 1'b0;
        nxt_busy     = r_busy;
        nxt_sda_oe   = r_sda_oe;

        if (w_start || w_stop) begin
            // Either bus condition ends any write in progress.
            if (r_is_write && (r_byte_cnt != '0)) begin
                nxt_rx_data  = r_rx_buf;
                nxt_rx_bytes = r_byte_cnt;
                nxt_rx_valid = 1'b1;
            end
            nxt_is_write = 1'b0;
            nxt_sda_oe   = 1'b0;
            nxt_bit_cnt  = '0;
            nxt_byte_cnt = '0;
            if (w_stop) begin
                nxt_state = ST_IDLE;
                nxt_busy  = 1'b0;
            end else begin
                nxt_state = ST_ADDR;
            end
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        nxt_shift = w_shift_in;
                        if (r_bit_cnt == 4'd7) begin
                            nxt_bit_cnt = '0;
                            if (w_shift_in[7:1] == ADDR) begin
                                nxt_state    = ST_ADDR_ACK;
                                nxt_busy     = 1'b1;
                                nxt_is_write = ~w_shift_in[0];
                                nxt_rx_buf   = '0;
                                nxt_byte_cnt = '0;
                                if (w_shift_in[0]) begin
                                    nxt_tx_buf = tx_data;
                                end
                            end else begin
                                nxt_state = ST_IGNORE;
                            end
                        end else begin
                            nxt_bit_cnt = r_bit_cnt + 4'd1;
                        end
                    end
                end

                // bit_cnt 0: waiting for 8th fall to assert ACK;
                // bit_cnt 1: ACK on the bus, waiting for 9th fall.
                // r_shift[0] still holds the R/W bit here.
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd0) begin
                            nxt_sda_oe  = 1'b1;
                            nxt_bit_cnt = 4'd1;
                        end else begin
                            nxt_bit_cnt = '0;
                            if (r_shift[0]) begin
                                nxt_state  = ST_TX;
                                nxt_shift  = w_tx_byte;
                                nxt_sda_oe = ~w_tx_byte[7];
                            end else begin
                                nxt_state  = ST_RX;
                                nxt_sda_oe = 1'b0;
                            end
                        end
                    end
                end

                ST_RX: begin
                    if (w_scl_rise) begin
                        nxt_shift = w_shift_in;
                        if (r_bit_cnt == 4'd7) begin
                            nxt_bit_cnt = '0;
                            nxt_state   = ST_RX_ACK;
                            case (r_byte_cnt)
                                3'd0:    nxt_rx_buf[31:24] = w_shift_in;
                                3'd1:    nxt_rx_buf[23:16] = w_shift_in;
                                3'd2:    nxt_rx_buf[15:8]  = w_shift_in;
                                3'd3:    nxt_rx_buf[7:0]   = w_shift_in;
                                default: ;
                            endcase
                        end else begin
                            nxt_bit_cnt = r_bit_cnt + 4'd1;
                        end
                    end
                end

                // Same two-phase use of bit_cnt as ADDR_ACK. A byte beyond
                // the word is left unacknowledged and the target drops out.
                ST_RX_ACK: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd0) begin
                            if (r_byte_cnt < I2C_MAX_BYTES) begin
                                nxt_sda_oe  = 1'b1;
                                nxt_bit_cnt = 4'd1;
                            end else begin
                                nxt_state = ST_IGNORE;
                            end
                        end else begin
                            nxt_sda_oe   = 1'b0;
                            nxt_byte_cnt = w_byte_inc;
                            nxt_bit_cnt  = '0;
                            nxt_state    = ST_RX;
                        end
                    end
                end

                // bit_cnt counts bits already clocked out; r_shift[7] is the
                // bit currently on the bus.
                ST_TX: begin
                    if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
                        nxt_bit_cnt = r_bit_cnt + 4'd1;
                    end
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            nxt_sda_oe = 1'b0;
                            nxt_state  = ST_TX_ACK;
                        end else begin
                            nxt_sda_oe = ~r_shift[6];
                            nxt_shift  = {r_shift[6:0], 1'b0};
                        end
                    end
                end

                // bit_cnt is 8 on entry; dropping it to 0 marks a seen ACK.
                ST_TX_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda) begin
                            nxt_state = ST_IGNORE;
                        end else begin
                            nxt_bit_cnt  = '0;
                            nxt_byte_cnt = w_byte_inc;
                        end
                    end
                    if (w_scl_fall && (r_bit_cnt == 4'd0)) begin
                        nxt_state  = ST_TX;
                        nxt_shift  = w_tx_byte;
                        nxt_sda_oe = ~w_tx_byte[7];
                    end
                end

                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign i2c_sda  = r_sda_oe ? 1'b0 : 1'bz;
    assign rx_data  = r_rx_data;
    assign rx_bytes = r_rx_bytes;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign state_o  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_slave
//  Description : Self-checking bench for i2c_slave. A bit-level bus master
//                drives directed and random transfers; expected ACKs, read
//                bytes and the captured write word come from a transfer-level
//                model of the target's rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_slave;

    localparam int         Q        = 5;       // clk cycles per quarter SCL
    localparam logic [6:0] DEV_ADDR = 7'h50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_drv = 1'b1;
    logic        sda_low = 1'b0;
    logic [31:0] tx_data = 32'h0;
    logic [31:0] rx_data;
    logic [2:0]  rx_bytes;
    logic        rx_valid;
    logic        busy;
    logic [2:0]  state_o;

    wire sda_bus;
    pullup (sda_bus);
    assign sda_bus = sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.ADDR(DEV_ADDR)) dut (
        .clk      (clk),
        .rst      (rst),
        .i2c_scl  (scl_drv),
        .i2c_sda  (sda_bus),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_bytes (rx_bytes),
        .rx_valid (rx_valid),
        .busy     (busy),
        .state_o  (state_o)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cur_txn  = 0;
    int          v_pulses = 0;
    int          v_cycles = 0;
    logic        prev_v   = 1'b0;
    logic        busy_seen = 1'b0;
    logic        in_xfer  = 1'b0;
    logic [31:0] m_rx_data  = 32'h0;
    logic [2:0]  m_rx_bytes = 3'd0;
    logic [7:0]  wr_bytes [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (txn %0d): got %h, expected %h", tag, cur_txn, got, exp);
        end
    endtask

    // rx_valid / busy observer
    always @(negedge clk) begin
        if (rx_valid) begin
            v_cycles++;
            if (!prev_v) v_pulses++;
        end
        prev_v = rx_valid;
        if (busy) busy_seen = 1'b1;
    end

    // ------------------------------------------------------------------
    // Bus master
    // ------------------------------------------------------------------
    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_low = ~b;
        wq();
        scl_drv = 1'b1;
        wq();
        s = sda_bus;
        wq();
        scl_drv = 1'b0;
        wq();
    endtask

    task automatic do_start();
        sda_low = 1'b1;
        wq();
        scl_drv = 1'b0;
        wq();
    endtask

    task automatic do_rstart();
        sda_low = 1'b0;
        wq();
        scl_drv = 1'b1;
        wq();
        sda_low = 1'b1;
        wq();
        scl_drv = 1'b0;
        wq();
    endtask

    task automatic do_stop();
        sda_low = 1'b1;
        wq();
        scl_drv = 1'b1;
        wq();
        sda_low = 1'b0;
        wq();
        wq();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic ack_it, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            b[i] = s;
        end
        bit_xfer(~ack_it, s);
    endtask

    // One transfer: address phase, n data bytes, ended by STOP or by a
    // repeated START that opens the next transfer.
    task automatic run_txn(input logic [6:0] a, input logic rw, input int n, input logic end_stop);
        logic        ack;
        logic [7:0]  got;
        logic        match;
        logic        fresh;
        logic [31:0] w;
        logic [31:0] exp_tx;
        int          exp_upd;

        cur_txn++;
        match   = (a == DEV_ADDR);
        fresh   = ~in_xfer;
        exp_tx  = tx_data;
        exp_upd = 0;
        v_pulses  = 0;
        v_cycles  = 0;
        busy_seen = 1'b0;

        if (fresh) do_start();
        send_byte({a, rw}, ack);
        check_eq("addr_ack", {31'b0, ack}, {31'b0, match});

        for (int i = 0; i < n; i++) begin
            if (!rw) begin
                send_byte(wr_bytes[i], ack);
                check_eq("wr_ack", {31'b0, ack}, {31'b0, (match && (i < 4))});
            end else begin
                recv_byte(i != n - 1, got);
                check_eq("rd_byte", {24'b0, got},
                         {24'b0, (match && (i < 4)) ? exp_tx[31 - 8*i -: 8] : 8'hFF});
            end
        end

        if (match && !rw && (n > 0)) begin
            w = 32'h0;
            for (int i = 0; i < n && i < 4; i++) w[31 - 8*i -: 8] = wr_bytes[i];
            m_rx_data  = w;
            m_rx_bytes = (n > 4) ? 3'd4 : 3'(n);
            exp_upd    = 1;
        end

        if (end_stop) begin
            do_stop();
            in_xfer = 1'b0;
        end else begin
            do_rstart();
            in_xfer = 1'b1;
        end
        repeat (8) @(negedge clk);

        check_eq("rxv_pulses", v_pulses, exp_upd);
        check_eq("rxv_cycles", v_cycles, exp_upd);
        check_eq("rx_data",  rx_data,  m_rx_data);
        check_eq("rx_bytes", {29'b0, rx_bytes}, {29'b0, m_rx_bytes});
        if (end_stop) begin
            check_eq("busy_after_stop", {31'b0, busy}, 32'd0);
            check_eq("state_after_stop", {29'b0, state_o}, 32'd0);
        end
        if (fresh) check_eq("busy_seen", {31'b0, busy_seen}, {31'b0, match});
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_sda",      {31'b0, sda_bus},  32'd1);
        check_eq("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check_eq("rst_busy",     {31'b0, busy},     32'd0);
        check_eq("rst_state",    {29'b0, state_o},  32'd0);
        check_eq("rst_rx_bytes", {29'b0, rx_bytes}, 32'd0);
        check_eq("rst_rx_data",  rx_data,           32'd0);
    endtask

    task automatic recover_from_reset();
        m_rx_data  = 32'h0;
        m_rx_bytes = 3'd0;
        repeat (3) @(negedge clk);
        sda_low = 1'b0;
        scl_drv = 1'b1;
        repeat (4) @(negedge clk);
        v_pulses = 0;
        rst = 1'b0;
        in_xfer = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("no_rxv_after_rst", v_pulses, 32'd0);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [6:0] ra;
        logic       rrw;
        int         rn;
        logic       rstop;

        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs();

        // Full four-byte write
        wr_bytes[0] = 8'hDE; wr_bytes[1] = 8'hAD; wr_bytes[2] = 8'hBE; wr_bytes[3] = 8'hEF;
        run_txn(DEV_ADDR, 1'b0, 4, 1'b1);
        check_eq("deadbeef", rx_data, 32'hDEADBEEF);

        // Short write, zero-filled
        wr_bytes[0] = 8'h12; wr_bytes[1] = 8'h34;
        run_txn(DEV_ADDR, 1'b0, 2, 1'b1);
        check_eq("short_wr", rx_data, 32'h12340000);

        // Read: four bytes then one past the word
        tx_data = 32'hCAFEF00D;
        run_txn(DEV_ADDR, 1'b1, 5, 1'b1);

        // Wrong address
        wr_bytes[0] = 8'h55; wr_bytes[1] = 8'hAA;
        run_txn(7'h51, 1'b0, 2, 1'b1);

        // Five-byte write: fifth byte refused
        for (int i = 0; i < 5; i++) wr_bytes[i] = 8'(8'h10 * (i + 1) + i);
        run_txn(DEV_ADDR, 1'b0, 5, 1'b1);

        // Reset during the 3rd bit of a write data byte
        cur_txn++;
        do_start();
        send_byte({DEV_ADDR, 1'b0}, ack);
        check_eq("pre_rst_ack", {31'b0, ack}, 32'd1);
        bit_xfer(1'b1, s);
        bit_xfer(1'b0, s);
        sda_low = 1'b0;
        wq();
        scl_drv = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        recover_from_reset();

        // Next full transfer after reset
        wr_bytes[0] = 8'hA5; wr_bytes[1] = 8'h5A; wr_bytes[2] = 8'h3C;
        run_txn(DEV_ADDR, 1'b0, 3, 1'b1);

        // Reset while the target is holding the address ACK
        cur_txn++;
        do_start();
        for (int i = 7; i >= 0; i--) bit_xfer((i == 0) ? 1'b0 : DEV_ADDR[i - 1], s);
        sda_low = 1'b0;
        wq();
        check_eq("ack_driven", {31'b0, sda_bus}, 32'd0);
        rst = 1'b1;
        #1;
        check_eq("ack_released_rst", {31'b0, sda_bus}, 32'd1);
        check_eq("ack_rst_busy", {31'b0, busy}, 32'd0);
        recover_from_reset();

        // Random transfers
        for (int t = 0; t < 20; t++) begin
            ra    = ($urandom_range(0, 3) == 0) ? 7'($urandom) : DEV_ADDR;
            rrw   = 1'($urandom);
            rn    = rrw ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 5));
            rstop = (t == 19) || ($urandom_range(0, 3) != 0);
            tx_data = $urandom;
            for (int i = 0; i < 8; i++) wr_bytes[i] = 8'($urandom);
            run_txn(ra, rrw, rn, rstop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
